hdr_sched: RTL and testbench
============================

# hdr_sched

Header-write scheduler sitting in the memclk domain ahead of the header accumulator. It takes free event-buffer addresses and issues them as "done" requests to the accumulator, with at most MAX_OUTSTANDING in flight. It matches the accumulator's completions back to the in-flight addresses. Finished events are released downstream strictly in issue order, each tagged with an error flag.

## Interface
- MAX_OUTSTANDING, 8: in-flight table depth; power of two, 2..16.
- ADDR_BITS, 13: event buffer address width; fixed at 13 for the current memory map.
- memclk  in  1  sole clock.
- memresetn  in  1  asynchronous, active-low reset.
- enable_i  in  1  permits new issues; drain continues when low.
- s_addr_tdata  in  16  [12:0] free buffer address; [15:13] ignored.
- s_addr_tvalid  in  1; s_addr_tready  out  1.
- m_done_tdata  out  16  {3'b000, addr}, to the accumulator done port.
- m_done_tvalid  out  1; m_done_tready  in  1.
- s_cmpl_tdata  in  24  [20:8] addr, [3:0] error code (nonzero = error).
- s_cmpl_tvalid  in  1; s_cmpl_tready  out  1.
- m_evt_tdata  out  16  [15] error, [14:13] 0, [12:0] addr.
- m_evt_tvalid  out  1; m_evt_tready  in  1.
- outstanding_o  out  5  occupied table entries.
- err_count_o  out  16  saturating count of errored completions.
- unmatched_o  out  1  sticky; a completion address hit no pending entry.

## Operation
- The table is a circular buffer of MAX_OUTSTANDING entries. Each entry holds {addr, pending, done, err}.
- Head and tail pointers are log2(MAX_OUTSTANDING)+1 bits wide, so the MSB distinguishes full from empty.
- **Issue FSM** (ISSUE_IDLE, ISSUE_WAIT):
  - ISSUE_IDLE: if enable_i, s_addr_tvalid and the table is not full: latch addr into m_done_tdata, set m_done_tvalid, write the entry at tail with pending=1, done=0, err=0, increment tail, go to ISSUE_WAIT.
  - ISSUE_WAIT: hold m_done_tvalid and data stable until m_done_tready, then return to ISSUE_IDLE.
  - s_addr_tready is asserted only in the ISSUE_IDLE accept cycle.
- **Completion path:**
  - s_cmpl_tready = 1 whenever out of reset.
  - On each handshake, search pending && !done entries from head toward tail; the oldest match gets done=1 and err=(code!=0).
  - An errored completion increments err_count_o, saturating at 16'hFFFF.
  - With no match, set unmatched_o. The table is unchanged. The completion is consumed.
- **Release path:**
  - When the head entry has done=1, present m_evt with {err, 2'b00, addr}.
  - On m_evt handshake, clear the entry and increment head.
  - A later done entry never releases ahead of an undone head.
- outstanding_o = tail − head, taken modulo the pointer width.

## Timing
- Reset values: m_done_tvalid=0, m_evt_tvalid=0, s_addr_tready=0, s_cmpl_tready=0, outstanding_o=0, err_count_o=0, unmatched_o=0, all table entries cleared, FSM in ISSUE_IDLE.
- Issue latency: s_addr handshake in cycle N gives m_done_tvalid in cycle N+1.
- A completion accepted in cycle N can drive m_evt_tvalid at the earliest in cycle N+1 (registered done bit).
- Issue-push, completion-mark and release-pop may all occur in the same cycle on different entries.
- Full table: s_addr_tready stays low. A pop in cycle N frees a slot, so an issue can be accepted in N+1.
- A completion can arrive for an entry while its m_done is still in ISSUE_WAIT; it still matches, because the entry is written at issue.
- Duplicate in-flight addresses are allowed; completions resolve oldest-first.
- Pointer wrap is natural binary rollover with no special case.
- enable_i falling mid-ISSUE_WAIT does not cancel the pending m_done.
- Asynchronous reset mid-operation drops all in-flight state immediately. Any completions that arrive later count as unmatched.

## Structure
- Package hdr_sched_pkg holds:
  - ADDR_BITS, the completion field offsets (CMPL_ADDR_LSB=8, CMPL_ERR_LSB=0) and EVT_ERR_BIT=15;
  - the typedef hdr_sched_entry_t {addr, pending, done, err}.
- One sub-module, hdr_sched_table: entry storage, head/tail pointers, oldest-match search and full/empty flags.
- The top level holds the issue FSM, the release handshake and the counters.

## Test plan
- Issue 0x0001, 0x0002, 0x0003, then complete 0x0002, 0x0001, 0x0003 with err=0 -> m_evt emits 0x0001, 0x0002, 0x0003 in that order, all with bit15=0.
- Fill 8 entries and hold m_done_tready=1 with no completions -> s_addr_tready stays 0 and outstanding_o=8. Complete and release one entry -> the next issue is accepted on the following cycle.
- Complete 0x1ABC with err=4'h3 -> m_evt_tdata=0x9ABC and err_count_o=1.
- Complete address 0x0777, which is not in flight -> unmatched_o=1, table unchanged, s_cmpl_tready stays 1.
- Issue 0x0010 twice, then complete 0x0010 with err=1 followed by err=0 -> the first released event is 0x8010 and the second is 0x0010.
- Assert reset with 5 entries in flight -> all outputs return to reset values and outstanding_o=0. After release, the first issue behaves normally.

Source files
------------

// File: rtl/hdr_sched_pkg.sv
// Shared constants, field offsets and types for the header-write scheduler.
package hdr_sched_pkg;

  localparam int ADDR_BITS     = 13;
  localparam int AXIS_W        = 16;
  localparam int CMPL_ADDR_LSB = 8;
  localparam int CMPL_ERR_LSB  = 0;
  localparam int CMPL_ERR_BITS = 4;
  localparam int EVT_ERR_BIT   = 15;

  typedef enum logic {
    ISSUE_IDLE,
    ISSUE_WAIT
  } issue_state_t;

  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    logic                 pending;
    logic                 done;
    logic                 err;
  } hdr_sched_entry_t;

endpackage

// File: rtl/hdr_sched_table.sv
// In-flight table: circular entry store, head/tail pointers and oldest-first
// completion matching.
module hdr_sched_table
  import hdr_sched_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int PTR_W = IDX_W + 1
) (
  input  logic                 memclk,
  input  logic                 memresetn,
  input  logic                 push,
  input  logic [ADDR_BITS-1:0] push_addr,
  input  logic                 cmpl_valid,
  input  logic [ADDR_BITS-1:0] cmpl_addr,
  input  logic                 cmpl_err,
  input  logic                 pop,
  output logic                 full,
  output logic                 empty,
  output hdr_sched_entry_t     head_entry,
  output logic                 match,
  output logic [PTR_W-1:0]     count
);

  hdr_sched_entry_t entries [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [IDX_W-1:0] head_idx, tail_idx, match_idx;

  assign head_idx   = head[IDX_W-1:0];
  assign tail_idx   = tail[IDX_W-1:0];
  assign empty      = (head == tail);
  assign full       = (head[PTR_W-1] != tail[PTR_W-1]) && (head_idx == tail_idx);
  assign count      = tail - head;
  assign head_entry = entries[head_idx];

  // Walk from head so the first hit is the oldest outstanding entry.
  always_comb begin
    // NOTE: defaults before the loop keep this purely combinational (no latch).
    match     = 1'b0;
    match_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [IDX_W-1:0] idx;
      idx = head_idx + IDX_W'(i);
      if (!match && entries[idx].pending && !entries[idx].done &&
          entries[idx].addr == cmpl_addr) begin
        match     = 1'b1;
        match_idx = idx;
      end
    end
  end

  always_ff @(posedge memclk or negedge memresetn) begin
    if (!memresetn) begin
      head <= '0;
      tail <= '0;
      // NOTE: the table is reset on purpose; a reset must drop every in-flight entry.
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else begin
      if (push) entries[tail_idx] <= '{addr: push_addr, pending: 1'b1, done: 1'b0, err: 1'b0};
      if (cmpl_valid && match) begin
        entries[match_idx].done <= 1'b1;
        entries[match_idx].err  <= cmpl_err;
      end
      if (pop) entries[head_idx] <= '0;
      tail <= tail + PTR_W'(push);
      head <= head + PTR_W'(pop);
    end
  end

endmodule

// File: rtl/hdr_sched.sv
// Header-write scheduler: issues free buffer addresses as done requests, matches
// completions, and releases finished events in issue order.
module hdr_sched
  import hdr_sched_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic              memclk,
  input  logic              memresetn,
  input  logic              enable_i,
  input  logic [15:0]       s_addr_tdata,
  input  logic              s_addr_tvalid,
  output logic              s_addr_tready,
  output logic [AXIS_W-1:0] m_done_tdata,
  output logic              m_done_tvalid,
  input  logic              m_done_tready,
  input  logic [23:0]       s_cmpl_tdata,
  input  logic              s_cmpl_tvalid,
  output logic              s_cmpl_tready,
  output logic [AXIS_W-1:0] m_evt_tdata,
  output logic              m_evt_tvalid,
  input  logic              m_evt_tready,
  output logic [4:0]        outstanding_o,
  output logic [15:0]       err_count_o,
  output logic              unmatched_o
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING) + 1;

  issue_state_t         state;
  logic                 run_q;
  logic                 full, empty, match, accept, cmpl_fire, cmpl_err, pop;
  logic [ADDR_BITS-1:0] cmpl_addr;
  logic [PTR_W-1:0]     count;
  hdr_sched_entry_t     head_entry;
  logic                 unused_bits;

  // run_q keeps both ready outputs low until the first clock after reset.
  assign s_addr_tready = run_q && (state == ISSUE_IDLE) && enable_i && !full;
  assign s_cmpl_tready = run_q;
  assign accept        = s_addr_tready && s_addr_tvalid;
  assign cmpl_fire     = s_cmpl_tready && s_cmpl_tvalid;
  assign cmpl_addr     = s_cmpl_tdata[CMPL_ADDR_LSB +: ADDR_BITS];
  assign cmpl_err      = |s_cmpl_tdata[CMPL_ERR_LSB +: CMPL_ERR_BITS];

  assign m_evt_tvalid  = head_entry.done;
  assign pop           = m_evt_tvalid && m_evt_tready;
  assign outstanding_o = 5'(count);

  always_comb begin
    m_evt_tdata                  = '0;
    m_evt_tdata[ADDR_BITS-1:0]   = head_entry.addr;
    m_evt_tdata[EVT_ERR_BIT]     = head_entry.err;
  end

  assign unused_bits = ^{s_addr_tdata[15:ADDR_BITS], s_cmpl_tdata[23:CMPL_ADDR_LSB+ADDR_BITS],
                         s_cmpl_tdata[CMPL_ADDR_LSB-1:CMPL_ERR_LSB+CMPL_ERR_BITS],
                         head_entry.pending, empty};

  hdr_sched_table #(.DEPTH(MAX_OUTSTANDING)) u_table (
    .memclk     (memclk),
    .memresetn  (memresetn),
    .push       (accept),
    .push_addr  (s_addr_tdata[ADDR_BITS-1:0]),
    .cmpl_valid (cmpl_fire),
    .cmpl_addr  (cmpl_addr),
    .cmpl_err   (cmpl_err),
    .pop        (pop),
    .full       (full),
    .empty      (empty),
    .head_entry (head_entry),
    .match      (match),
    .count      (count)
  );

  always_ff @(posedge memclk or negedge memresetn) begin
    if (!memresetn) begin
      state         <= ISSUE_IDLE;
      m_done_tvalid <= 1'b0;
      m_done_tdata  <= '0;
    end else begin
      case (state)
        ISSUE_IDLE: if (accept) begin
          m_done_tdata  <= {{(AXIS_W-ADDR_BITS){1'b0}}, s_addr_tdata[ADDR_BITS-1:0]};
          m_done_tvalid <= 1'b1;
          state         <= ISSUE_WAIT;
        end
        ISSUE_WAIT: if (m_done_tready) begin
          m_done_tvalid <= 1'b0;
          state         <= ISSUE_IDLE;
        end
        default: state <= ISSUE_IDLE;
      endcase
    end
  end

  always_ff @(posedge memclk or negedge memresetn) begin
    if (!memresetn) begin
      run_q       <= 1'b0;
      err_count_o <= '0;
      unmatched_o <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (cmpl_fire && cmpl_err && err_count_o != 16'hFFFF) err_count_o <= err_count_o + 16'd1;
      if (cmpl_fire && !match) unmatched_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hdr_sched.sv
// Self-checking bench for hdr_sched: an issue-order scoreboard checks every
// m_done and m_evt handshake; scenario tasks check flags and counters inline.
module tb_hdr_sched;

  logic        memclk = 1'b0;
  logic        memresetn = 1'b0;
  logic        enable_i = 1'b1;
  logic [15:0] s_addr_tdata = '0;
  logic        s_addr_tvalid = 1'b0;
  logic        s_addr_tready;
  logic [15:0] m_done_tdata;
  logic        m_done_tvalid;
  logic        m_done_tready = 1'b1;
  logic [23:0] s_cmpl_tdata = '0;
  logic        s_cmpl_tvalid = 1'b0;
  logic        s_cmpl_tready;
  logic [15:0] m_evt_tdata;
  logic        m_evt_tvalid;
  logic        m_evt_tready = 1'b1;
  logic [4:0]  outstanding_o;
  logic [15:0] err_count_o;
  logic        unmatched_o;

  typedef struct {
    logic [12:0] addr;
    bit          done;
    bit          err;
  } mdl_t;

  mdl_t        mdl[$];
  logic [15:0] done_q[$];
  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_err = '0;
  bit          exp_unm = 1'b0;

  hdr_sched #(.MAX_OUTSTANDING(8)) dut (
    .memclk        (memclk),
    .memresetn     (memresetn),
    .enable_i      (enable_i),
    .s_addr_tdata  (s_addr_tdata),
    .s_addr_tvalid (s_addr_tvalid),
    .s_addr_tready (s_addr_tready),
    .m_done_tdata  (m_done_tdata),
    .m_done_tvalid (m_done_tvalid),
    .m_done_tready (m_done_tready),
    .s_cmpl_tdata  (s_cmpl_tdata),
    .s_cmpl_tvalid (s_cmpl_tvalid),
    .s_cmpl_tready (s_cmpl_tready),
    .m_evt_tdata   (m_evt_tdata),
    .m_evt_tvalid  (m_evt_tvalid),
    .m_evt_tready  (m_evt_tready),
    .outstanding_o (outstanding_o),
    .err_count_o   (err_count_o),
    .unmatched_o   (unmatched_o)
  );

  always #5 memclk = ~memclk;

  // Handshakes are sampled mid-cycle; they complete on the following rising edge.
  always @(negedge memclk) begin
    if (memresetn && m_evt_tvalid && m_evt_tready) begin
      total++;
      if (mdl.size() == 0) begin
        bad++;
        $display("FAIL evt_unexpected got=%h required=none", m_evt_tdata);
      end else begin
        if (!mdl[0].done || m_evt_tdata !== {mdl[0].err, 2'b00, mdl[0].addr}) begin
          bad++;
          $display("FAIL evt_order got=%h required=%h (head done=%0b)", m_evt_tdata,
                   {mdl[0].err, 2'b00, mdl[0].addr}, mdl[0].done);
        end
        void'(mdl.pop_front());
      end
    end
    if (memresetn && m_done_tvalid && m_done_tready) begin
      total++;
      if (done_q.size() == 0) begin
        bad++;
        $display("FAIL done_unexpected got=%h required=none", m_done_tdata);
      end else begin
        if (m_done_tdata !== done_q[0]) begin
          bad++;
          $display("FAIL done_data got=%h required=%h", m_done_tdata, done_q[0]);
        end
        void'(done_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge memclk);
    #1;
  endtask

  task automatic issue(input logic [12:0] a);
    int n = 0;
    s_addr_tdata  = {3'($urandom_range(0, 7)), a};
    s_addr_tvalid = 1'b1;
    while (!s_addr_tready && n < 50) begin
      tick();
      n++;
    end
    total++;
    if (s_addr_tready !== 1'b1) begin
      bad++;
      $display("FAIL issue_accept addr=%h tready=%b required=1", a, s_addr_tready);
    end else begin
      mdl.push_back(mdl_t'{addr: a, done: 1'b0, err: 1'b0});
      done_q.push_back({3'b000, a});
    end
    tick();
    s_addr_tvalid = 1'b0;
  endtask

  task automatic complete(input logic [12:0] a, input logic [3:0] code);
    int n = 0;
    bit hit = 1'b0;
    s_cmpl_tdata  = {3'($urandom_range(0, 7)), a, 4'($urandom_range(0, 15)), code};
    s_cmpl_tvalid = 1'b1;
    while (!s_cmpl_tready && n < 50) begin
      tick();
      n++;
    end
    total++;
    if (s_cmpl_tready !== 1'b1) begin
      bad++;
      $display("FAIL cmpl_ready addr=%h tready=%b required=1", a, s_cmpl_tready);
    end
    for (int i = 0; i < mdl.size(); i++) begin
      if (!hit && !mdl[i].done && mdl[i].addr == a) begin
        mdl_t e = mdl[i];
        e.done = 1'b1;
        e.err  = (code != 4'd0);
        mdl[i] = e;
        hit    = 1'b1;
      end
    end
    if (!hit) exp_unm = 1'b1;
    if (code != 4'd0 && exp_err != 16'hFFFF) exp_err++;
    tick();
    s_cmpl_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((outstanding_o != 5'd0 || m_done_tvalid) && n < 200) begin
      tick();
      n++;
    end
    total++;
    if (outstanding_o !== 5'd0 || mdl.size() != 0) begin
      bad++;
      $display("FAIL drain outstanding=%0d model_left=%0d required=0/0", outstanding_o, mdl.size());
    end
  endtask

  task automatic test_reset();
    s_addr_tvalid = 1'b1;
    s_cmpl_tvalid = 1'b1;
    s_cmpl_tdata  = 24'h000100;
    tick();
    total++;
    if ({s_addr_tready, s_cmpl_tready, m_done_tvalid, m_evt_tvalid, outstanding_o,
         err_count_o, unmatched_o} !== 26'd0) begin
      bad++;
      $display("FAIL reset_values ardy=%b crdy=%b dv=%b ev=%b out=%0d err=%0d unm=%b required=all 0",
               s_addr_tready, s_cmpl_tready, m_done_tvalid, m_evt_tvalid, outstanding_o,
               err_count_o, unmatched_o);
    end
    s_addr_tvalid = 1'b0;
    s_cmpl_tvalid = 1'b0;
    tick();
    memresetn = 1'b1;
    tick();
  endtask

  task automatic test_in_order();
    issue(13'h0001);
    issue(13'h0002);
    issue(13'h0003);
    total++;
    if (outstanding_o !== 5'd3) begin
      bad++;
      $display("FAIL inorder_outstanding got=%0d required=3", outstanding_o);
    end
    complete(13'h0002, 4'h0);
    total++;
    if (m_evt_tvalid !== 1'b0) begin
      bad++;
      $display("FAIL inorder_hold got=%b required=0", m_evt_tvalid);
    end
    complete(13'h0001, 4'h0);
    total++;
    if (m_evt_tvalid !== 1'b1 || m_evt_tdata !== 16'h0001) begin
      bad++;
      $display("FAIL inorder_first got=%b/%h required=1/0001", m_evt_tvalid, m_evt_tdata);
    end
    complete(13'h0003, 4'h0);
    drain();
  endtask

  task automatic test_error();
    issue(13'h1ABC);
    m_evt_tready = 1'b0;
    complete(13'h1ABC, 4'h3);
    total++;
    if (m_evt_tvalid !== 1'b1 || m_evt_tdata !== 16'h9ABC || err_count_o !== 16'd1) begin
      bad++;
      $display("FAIL error_evt got=%b/%h cnt=%0d required=1/9abc cnt=1",
               m_evt_tvalid, m_evt_tdata, err_count_o);
    end
    m_evt_tready = 1'b1;
    drain();
  endtask

  task automatic test_unmatched();
    issue(13'h0005);
    total++;
    if (unmatched_o !== 1'b0) begin
      bad++;
      $display("FAIL unmatched_pre got=%b required=0", unmatched_o);
    end
    complete(13'h0777, 4'h0);
    total++;
    if (unmatched_o !== 1'b1 || outstanding_o !== 5'd1 || m_evt_tvalid !== 1'b0 ||
        s_cmpl_tready !== 1'b1) begin
      bad++;
      $display("FAIL unmatched got unm=%b out=%0d ev=%b crdy=%b required=1/1/0/1",
               unmatched_o, outstanding_o, m_evt_tvalid, s_cmpl_tready);
    end
    complete(13'h0005, 4'h0);
    drain();
  endtask

  task automatic test_duplicate();
    issue(13'h0010);
    issue(13'h0010);
    complete(13'h0010, 4'h1);
    complete(13'h0010, 4'h0);
    drain();
    total++;
    if (err_count_o !== exp_err) begin
      bad++;
      $display("FAIL dup_errcount got=%0d required=%0d", err_count_o, exp_err);
    end
  endtask

  task automatic test_stall();
    bit ok = 1'b1;
    m_done_tready = 1'b0;
    issue(13'h0055);
    total++;
    if (m_done_tvalid !== 1'b1 || m_done_tdata !== 16'h0055) begin
      bad++;
      $display("FAIL issue_latency got=%b/%h required=1/0055", m_done_tvalid, m_done_tdata);
    end
    enable_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (m_done_tvalid !== 1'b1 || m_done_tdata !== 16'h0055 || s_addr_tready !== 1'b0) ok = 1'b0;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL stall_hold got=%b/%h ardy=%b required=1/0055/0",
               m_done_tvalid, m_done_tdata, s_addr_tready);
    end
    m_done_tready = 1'b1;
    tick();
    total++;
    if (m_done_tvalid !== 1'b0) begin
      bad++;
      $display("FAIL stall_release got=%b required=0", m_done_tvalid);
    end
    enable_i = 1'b1;
    complete(13'h0055, 4'h0);
    drain();
  endtask

  task automatic test_full();
    bit ok = 1'b1;
    for (int i = 0; i < 8; i++) issue(13'h0100 + 13'(i));
    s_addr_tdata  = 16'h0200;
    s_addr_tvalid = 1'b1;
    m_evt_tready  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (s_addr_tready !== 1'b0 || outstanding_o !== 5'd8) ok = 1'b0;
      tick();
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL full_block ardy=%b out=%0d required=0/8", s_addr_tready, outstanding_o);
    end
    complete(13'h0100, 4'h0);
    total++;
    if (m_evt_tvalid !== 1'b1 || m_evt_tdata !== 16'h0100 || s_addr_tready !== 1'b0) begin
      bad++;
      $display("FAIL full_head got=%b/%h ardy=%b required=1/0100/0",
               m_evt_tvalid, m_evt_tdata, s_addr_tready);
    end
    m_evt_tready = 1'b1;
    tick();
    m_evt_tready = 1'b0;
    total++;
    if (s_addr_tready !== 1'b1) begin
      bad++;
      $display("FAIL full_reopen got=%b required=1", s_addr_tready);
    end else begin
      mdl.push_back(mdl_t'{addr: 13'h0200, done: 1'b0, err: 1'b0});
      done_q.push_back(16'h0200);
    end
    tick();
    s_addr_tvalid = 1'b0;
    total++;
    if (outstanding_o !== 5'd8) begin
      bad++;
      $display("FAIL full_refill got=%0d required=8", outstanding_o);
    end
    m_evt_tready = 1'b1;
    for (int i = 1; i < 8; i++) complete(13'h0100 + 13'(i), 4'h0);
    complete(13'h0200, 4'h0);
    drain();
  endtask

  task automatic test_back_to_back();
    logic [12:0] addrs [20];
    logic [3:0]  code;
    for (int i = 0; i < 20; i++) begin
      addrs[i] = 13'($urandom);
      issue(addrs[i]);
      if (i >= 3) begin
        code = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
        complete(addrs[i-3], code);
      end
    end
    for (int i = 17; i < 20; i++) complete(addrs[i], 4'h0);
    drain();
    total++;
    if (err_count_o !== exp_err || unmatched_o !== exp_unm) begin
      bad++;
      $display("FAIL b2b_counters err=%0d unm=%b required=%0d/%b",
               err_count_o, unmatched_o, exp_err, exp_unm);
    end
  endtask

  task automatic test_reset_midflight();
    m_evt_tready = 1'b0;
    for (int i = 0; i < 5; i++) issue(13'h0300 + 13'(i));
    complete(13'h0301, 4'h2);
    total++;
    if (outstanding_o !== 5'd5) begin
      bad++;
      $display("FAIL midrst_pre got=%0d required=5", outstanding_o);
    end
    memresetn = 1'b0;
    #1;
    total++;
    if ({s_addr_tready, s_cmpl_tready, m_done_tvalid, m_evt_tvalid, outstanding_o,
         err_count_o, unmatched_o} !== 26'd0) begin
      bad++;
      $display("FAIL midrst_values ardy=%b crdy=%b dv=%b ev=%b out=%0d err=%0d unm=%b required=all 0",
               s_addr_tready, s_cmpl_tready, m_done_tvalid, m_evt_tvalid, outstanding_o,
               err_count_o, unmatched_o);
    end
    mdl.delete();
    done_q.delete();
    exp_err = '0;
    exp_unm = 1'b0;
    tick();
    memresetn = 1'b1;
    m_evt_tready = 1'b1;
    tick();
    complete(13'h0300, 4'h0);
    total++;
    if (unmatched_o !== 1'b1 || outstanding_o !== 5'd0) begin
      bad++;
      $display("FAIL midrst_stale got unm=%b out=%0d required=1/0", unmatched_o, outstanding_o);
    end
    issue(13'h0042);
    total++;
    if (m_done_tvalid !== 1'b1 || m_done_tdata !== 16'h0042 || outstanding_o !== 5'd1) begin
      bad++;
      $display("FAIL midrst_issue got=%b/%h out=%0d required=1/0042/1",
               m_done_tvalid, m_done_tdata, outstanding_o);
    end
    complete(13'h0042, 4'h0);
    drain();
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_error();
    test_unmatched();
    test_duplicate();
    test_stall();
    test_full();
    test_back_to_back();
    test_reset_midflight();
    tick();
    total++;
    if (done_q.size() != 0) begin
      bad++;
      $display("FAIL done_leftover got=%0d required=0", done_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
